// File: rtl/nonpivot_cover_checker_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// nonpivot_cover_checker_pkg
//   Constants and types shared by the BIRA non-pivot cover checker slice:
//   address/bank widths, the packed pivot word width, default sizing for the
//   non-pivot CAM and analyzer latency, and the checker FSM state encoding.
// -----------------------------------------------------------------------------
package nonpivot_cover_checker_pkg;

    localparam int ADDR_W          = 10;
    localparam int BNK_W           = 2;
    // One pivot coordinate as carried internally: {bank, address}.
    localparam int PIVOT_W         = ADDR_W + BNK_W;

    localparam int NP_ENTRIES_DFLT = 8;
    localparam int ANA_LAT_DFLT    = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/nonpivot_cover_checker_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// nonpivot_cover_checker_if
//   Bundles the two buses the checker talks to:
//     - non-pivot CAM read port : np_rd_idx (out of checker), np_rd_vld,
//                                 np_rd_raddr, np_rd_caddr, np_rd_rbnk,
//                                 np_rd_cbnk (into checker, combinational read)
//     - analyzer port           : NPr_addr, NPc_addr, NPr_bnk, NPc_bnk (out of
//                                 checker, registered), cover_in (into checker)
//   master = checker side, slave = CAM/analyzer side.
// -----------------------------------------------------------------------------
interface nonpivot_cover_checker_if
    import nonpivot_cover_checker_pkg::*;
#(
    parameter int NP_ENTRIES = NP_ENTRIES_DFLT
);
    localparam int IDX_W = $clog2(NP_ENTRIES);

    // CAM read port
    logic [IDX_W-1:0]  np_rd_idx;
    logic              np_rd_vld;
    logic [ADDR_W-1:0] np_rd_raddr;
    logic [ADDR_W-1:0] np_rd_caddr;
    logic [BNK_W-1:0]  np_rd_rbnk;
    logic [BNK_W-1:0]  np_rd_cbnk;

    // Analyzer port
    logic [ADDR_W-1:0] NPr_addr;
    logic [ADDR_W-1:0] NPc_addr;
    logic [BNK_W-1:0]  NPr_bnk;
    logic [BNK_W-1:0]  NPc_bnk;
    logic              cover_in;

    modport master (
        output np_rd_idx,
        input  np_rd_vld, np_rd_raddr, np_rd_caddr, np_rd_rbnk, np_rd_cbnk,
        output NPr_addr, NPc_addr, NPr_bnk, NPc_bnk,
        input  cover_in
    );

    modport slave (
        input  np_rd_idx,
        output np_rd_vld, np_rd_raddr, np_rd_caddr, np_rd_rbnk, np_rd_cbnk,
        input  NPr_addr, NPc_addr, NPr_bnk, NPc_bnk,
        output cover_in
    );

endinterface

// File: rtl/nonpivot_cover_checker_np_tag_pipe.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// nonpivot_cover_checker_np_tag_pipe
//   Shift register of {occupied, vld, idx} tags that travels alongside the
//   analyzer so each returning cover bit can be matched to the CAM entry it
//   belongs to. A tag pushed at a clock edge reaches the last stage DEPTH-1
//   edges later, which is the cycle its cover bit is valid.
//   Ports:
//     clk, rst        clock, synchronous active-low reset
//     flush           empty every stage at the next edge (wins over push)
//     push            insert a tag this cycle
//     push_vld        tag's entry holds a real fault
//     push_idx        tag's CAM index
//     ret_occ         last stage holds a tag (retiring this cycle)
//     ret_vld         retiring tag is a real fault
//     ret_idx         retiring tag's CAM index
//     upstream_empty  all stages except the last are empty, i.e. after this
//                     cycle's retirement nothing is left (when not pushing)
// -----------------------------------------------------------------------------
module nonpivot_cover_checker_np_tag_pipe #(
    parameter int DEPTH = 2,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             push_vld,
    input  logic [IDX_W-1:0] push_idx,
    output logic             ret_occ,
    output logic             ret_vld,
    output logic [IDX_W-1:0] ret_idx,
    output logic             upstream_empty
);

    // Occupancy is kept apart from vld: an invalid entry still occupies a
    // slot so the drain logic waits for it.
    logic [DEPTH-1:0] occ_q;
    logic [DEPTH-1:0] vld_q;
    logic [IDX_W-1:0] idx_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            occ_q <= '0;
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            occ_q    <= {occ_q[DEPTH-2:0], push};
            vld_q    <= {vld_q[DEPTH-2:0], push && push_vld};
            idx_q[0] <= push_idx;
            for (int i = 1; i < DEPTH; i++) begin
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    assign ret_occ        = occ_q[DEPTH-1];
    assign ret_vld        = vld_q[DEPTH-1];
    assign ret_idx        = idx_q[DEPTH-1];
    assign upstream_empty = ~|occ_q[DEPTH-2:0];

endmodule

// File: rtl/nonpivot_cover_checker.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// nonpivot_cover_checker
//   For the repair candidate currently selected upstream, walks the non-pivot
//   fault CAM one entry per cycle, presents each entry's row/col address and
//   bank to the analyzer, and checks the cover bit that comes back ANA_LAT
//   cycles later. Reports covered=1 when every valid entry is covered, or
//   covered=0 plus fail_idx for the first uncovered one (scan aborts there).
//
//   Control protocol: start is a one-cycle request accepted only while idle
//   (busy=0); there is no back-pressure. Once accepted, busy stays high until
//   the cycle done pulses; covered/fail_idx are valid from that cycle and held
//   until the next accepted start. clr abandons a scan without a done pulse.
//
//   Ports:
//     clk, rst     clock, synchronous active-low reset
//     start        begin scan (idle only)
//     clr          abort to idle, no done; beats start
//     bus          CAM read port + analyzer port (master side)
//     busy         scan in progress
//     done         one-cycle verdict strobe
//     covered      verdict, held
//     fail_idx     first uncovered entry, held
//     state_dbg    current FSM state
// -----------------------------------------------------------------------------
module nonpivot_cover_checker
    import nonpivot_cover_checker_pkg::*;
#(
    parameter int NP_ENTRIES = NP_ENTRIES_DFLT,
    parameter int ANA_LAT    = ANA_LAT_DFLT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          clr,
    nonpivot_cover_checker_if.master      bus,
    output logic                          busy,
    output logic                          done,
    output logic                          covered,
    output logic [$clog2(NP_ENTRIES)-1:0] fail_idx,
    output state_t                        state_dbg
);

    localparam int IDX_W = $clog2(NP_ENTRIES);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [PIVOT_W-1:0] np_row_q;   // {bank, address}
    logic [PIVOT_W-1:0] np_col_q;
    logic               covered_q;
    logic [IDX_W-1:0]   fail_idx_q;

    // Control decoded by the next-state logic
    logic start_acc;
    logic push;
    logic flush;
    logic load_fail;
    logic set_covered;

    // Tag pipe view
    logic             ret_occ;
    logic             ret_vld;
    logic [IDX_W-1:0] ret_idx;
    logic             upstream_empty;

    logic last_issue;
    logic retire_fail;

    assign last_issue  = (idx_q == IDX_W'(NP_ENTRIES - 1));
    // Invalid tags retire silently whatever the analyzer returns.
    assign retire_fail = ((state_q == ST_SCAN) || (state_q == ST_DRAIN)) &&
                         ret_occ && ret_vld && !bus.cover_in;

    // -------------------------------------------------------------------------
    // Next state / control
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        start_acc   = 1'b0;
        push        = 1'b0;
        flush       = 1'b0;
        load_fail   = 1'b0;
        set_covered = 1'b0;

        if (clr) begin
            state_d = ST_IDLE;
            flush   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        start_acc = 1'b1;
                        state_d   = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    // A failure retiring on the last issue cycle still wins:
                    // nothing further is issued and DRAIN is skipped.
                    if (retire_fail) begin
                        load_fail = 1'b1;
                        flush     = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        push = 1'b1;
                        if (last_issue) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (retire_fail) begin
                        load_fail = 1'b1;
                        flush     = 1'b1;
                        state_d   = ST_DONE;
                    end else if (upstream_empty) begin
                        // The tag retiring now (if any) is the final one.
                        set_covered = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            np_row_q   <= '0;
            np_col_q   <= '0;
            covered_q  <= 1'b0;
            fail_idx_q <= '0;
        end else begin
            state_q <= state_d;

            // idx parks on the last entry; it only returns to 0 on a start.
            if (start_acc) begin
                idx_q <= '0;
            end else if (push && !last_issue) begin
                idx_q <= idx_q + IDX_W'(1);
            end

            if (push) begin
                np_row_q <= {bus.np_rd_rbnk, bus.np_rd_raddr};
                np_col_q <= {bus.np_rd_cbnk, bus.np_rd_caddr};
            end

            if (start_acc) begin
                covered_q  <= 1'b0;
                fail_idx_q <= '0;
            end else if (load_fail) begin
                covered_q  <= 1'b0;
                fail_idx_q <= ret_idx;
            end else if (set_covered) begin
                covered_q  <= 1'b1;
            end
        end
    end

    nonpivot_cover_checker_np_tag_pipe #(
        .DEPTH (ANA_LAT + 1),
        .IDX_W (IDX_W)
    ) u_tag_pipe (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .push           (push),
        .push_vld       (bus.np_rd_vld),
        .push_idx       (idx_q),
        .ret_occ        (ret_occ),
        .ret_vld        (ret_vld),
        .ret_idx        (ret_idx),
        .upstream_empty (upstream_empty)
    );

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.np_rd_idx = idx_q;
    assign bus.NPr_addr  = np_row_q[ADDR_W-1:0];
    assign bus.NPr_bnk   = np_row_q[PIVOT_W-1:ADDR_W];
    assign bus.NPc_addr  = np_col_q[ADDR_W-1:0];
    assign bus.NPc_bnk   = np_col_q[PIVOT_W-1:ADDR_W];

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign covered   = covered_q;
    assign fail_idx  = fail_idx_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_nonpivot_cover_checker.sv
`timescale 1ns/1ps
module tb_nonpivot_cover_checker;
    import nonpivot_cover_checker_pkg::*;

    localparam int NP  = 8;
    localparam int LAT = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic start;
    logic clr;
    always #5 clk = ~clk;

    logic       busy, done, covered;
    logic [2:0] fail_idx;
    state_t     state_dbg;

    nonpivot_cover_checker_if #(.NP_ENTRIES(NP)) bus ();

    nonpivot_cover_checker #(
        .NP_ENTRIES (NP),
        .ANA_LAT    (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .clr       (clr),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .covered   (covered),
        .fail_idx  (fail_idx),
        .state_dbg (state_dbg)
    );

    // ---------------- CAM and analyzer models ----------------
    logic [7:0] vld_map = 8'h00;   // which entries hold a fault
    logic [7:0] cov_map = 8'h00;   // analyzer answer per entry

    function automatic logic [9:0] ent_raddr(input logic [2:0] k);
        int ki;
        ki = int'(k);
        return {7'(ki * 5 + 3), k};   // low 3 bits identify the entry
    endfunction
    function automatic logic [9:0] ent_caddr(input logic [2:0] k);
        int ki;
        ki = int'(k);
        return 10'(ki * 41 + 100);
    endfunction
    function automatic logic [1:0] ent_rbnk(input logic [2:0] k);
        return k[1:0];
    endfunction
    function automatic logic [1:0] ent_cbnk(input logic [2:0] k);
        return ~k[1:0];
    endfunction
    function automatic logic [23:0] ent_np(input logic [2:0] k);
        return {ent_rbnk(k), ent_raddr(k), ent_cbnk(k), ent_caddr(k)};
    endfunction

    always_comb begin
        bus.np_rd_vld   = vld_map[bus.np_rd_idx];
        bus.np_rd_raddr = ent_raddr(bus.np_rd_idx);
        bus.np_rd_caddr = ent_caddr(bus.np_rd_idx);
        bus.np_rd_rbnk  = ent_rbnk(bus.np_rd_idx);
        bus.np_rd_cbnk  = ent_cbnk(bus.np_rd_idx);
    end

    // Registered lookup: answer for the entry on NP* appears one cycle later.
    always @(posedge clk) begin
        bus.cover_in <= cov_map[bus.NPr_addr[2:0]];
    end

    // ---------------- scoreboard ----------------
    int n_vec  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act);
        logic [31:0] exp_v;
        exp_v = exp_q.pop_front();
        n_vec++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    task automatic expect_check(input string name, input logic [31:0] act,
                                input logic [31:0] exp_v);
        exp_q.push_back(exp_v);
        check(name, act);
    endtask

    // ---------------- driver tasks ----------------
    // Each cycle: inputs change 1ns after the rising edge, outputs are
    // sampled on the falling edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    typedef struct {
        string      name;
        logic [7:0] vld;
        logic [7:0] cov;
        int         done_cyc;
        logic       exp_cov;
        logic [2:0] exp_fi;
    } vec_t;

    vec_t vecs[9];

    // One scan: start in cycle 0, observe cycles 0..14.
    task automatic run_vec(input vec_t v);
        int ent;
        vld_map = v.vld;
        cov_map = v.cov;
        tick;
        start = 1'b1;
        sample;
        expect_check($sformatf("%s busy c0", v.name), 32'(busy), 32'd0);
        for (int c = 1; c <= 14; c++) begin
            tick;
            start = 1'b0;
            sample;
            expect_check($sformatf("%s busy c%0d", v.name, c), 32'(busy),
                         32'(c <= v.done_cyc));
            expect_check($sformatf("%s done c%0d", v.name, c), 32'(done),
                         32'(c == v.done_cyc));
            if (c >= 2 && c < v.done_cyc) begin
                ent = (c - 2 > 7) ? 7 : c - 2;
                expect_check($sformatf("%s np c%0d", v.name, c),
                             32'({bus.NPr_bnk, bus.NPr_addr, bus.NPc_bnk, bus.NPc_addr}),
                             32'(ent_np(3'(ent))));
            end
            if (c >= v.done_cyc && c <= v.done_cyc + 1) begin
                expect_check($sformatf("%s covered c%0d", v.name, c), 32'(covered),
                             32'(v.exp_cov));
                expect_check($sformatf("%s fail_idx c%0d", v.name, c), 32'(fail_idx),
                             32'(v.exp_fi));
            end
        end
    endtask

    // ---------------- test ----------------
    initial begin
        rst   = 1'b0;
        start = 1'b0;
        clr   = 1'b0;

        // failure at entry k -> done in cycle k+4; clean -> cycle 11
        vecs[0] = '{"all_cov",    8'hff, 8'hff, 11, 1'b1, 3'd0};
        vecs[1] = '{"unc3",       8'hff, 8'hf7,  7, 1'b0, 3'd3};
        vecs[2] = '{"inv2_5",     8'hdb, 8'hdb, 11, 1'b1, 3'd0};
        vecs[3] = '{"all_inv",    8'h00, 8'h00, 11, 1'b1, 3'd0};
        vecs[4] = '{"unc0",       8'hff, 8'hfe,  4, 1'b0, 3'd0};
        vecs[5] = '{"unc7",       8'hff, 8'h7f, 11, 1'b0, 3'd7};
        vecs[6] = '{"unc5_last",  8'hff, 8'hdf,  9, 1'b0, 3'd5};
        vecs[7] = '{"unc4_7",     8'hff, 8'h6f,  8, 1'b0, 3'd4};
        vecs[8] = '{"inv4_unc7",  8'hef, 8'h6f, 11, 1'b0, 3'd7};

        // Reset state
        tick;
        tick;
        sample;
        expect_check("rst busy",     32'(busy),      32'd0);
        expect_check("rst done",     32'(done),      32'd0);
        expect_check("rst covered",  32'(covered),   32'd0);
        expect_check("rst fail_idx", 32'(fail_idx),  32'd0);
        expect_check("rst state",    32'(state_dbg), 32'(ST_IDLE));
        expect_check("rst np",
                     32'({bus.NPr_bnk, bus.NPr_addr, bus.NPc_bnk, bus.NPc_addr}), 32'd0);
        tick;
        rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
        end

        // clr in cycle 5, restart in cycle 8: only the second scan finishes.
        vld_map = 8'hff;
        cov_map = 8'hff;
        tick;
        start = 1'b1;
        sample;
        for (int c = 1; c <= 22; c++) begin
            tick;
            start = (c == 8);
            clr   = (c == 5);
            sample;
            expect_check($sformatf("clr busy c%0d", c), 32'(busy),
                         32'((c <= 5) || (c >= 9 && c <= 19)));
            expect_check($sformatf("clr done c%0d", c), 32'(done), 32'(c == 19));
            if (c == 7) begin
                expect_check("clr state c7", 32'(state_dbg), 32'(ST_IDLE));
            end
            if (c == 19) begin
                expect_check("clr covered c19", 32'(covered), 32'd1);
            end
        end

        // start pulsed in cycles 0 and 4: a single scan, done in cycle 11.
        tick;
        start = 1'b1;
        sample;
        for (int c = 1; c <= 14; c++) begin
            tick;
            start = (c == 4);
            sample;
            expect_check($sformatf("dbl busy c%0d", c), 32'(busy), 32'(c <= 11));
            expect_check($sformatf("dbl done c%0d", c), 32'(done), 32'(c == 11));
        end

        // rst low in cycle 6 of a scan.
        tick;
        start = 1'b1;
        sample;
        for (int c = 1; c <= 10; c++) begin
            tick;
            start = 1'b0;
            rst   = (c == 6) ? 1'b0 : 1'b1;
            sample;
            if (c == 6) begin
                expect_check("mrst busy c6", 32'(busy), 32'd1);
            end
            if (c == 7) begin
                expect_check("mrst state c7",    32'(state_dbg), 32'(ST_IDLE));
                expect_check("mrst covered c7",  32'(covered),   32'd0);
                expect_check("mrst fail_idx c7", 32'(fail_idx),  32'd0);
                expect_check("mrst np c7",
                             32'({bus.NPr_bnk, bus.NPr_addr, bus.NPc_bnk, bus.NPc_addr}),
                             32'd0);
            end
            if (c >= 7) begin
                expect_check($sformatf("mrst busy c%0d", c), 32'(busy), 32'd0);
                expect_check($sformatf("mrst done c%0d", c), 32'(done), 32'd0);
            end
        end
        // A following scan runs normally.
        run_vec(vecs[1]);
        run_vec(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
